// File: rtl/pc_branch_unit.sv
// Purpose: program counter plus next-PC selection (sequential, jump, beq/bne, halt) with a saturating redirect counter.
// Latency: pcOut, taken, halted, ctrlErr and takenCount update one clk edge after the inputs are sampled; pcPlus4 is combinational.
// Backpressure: en=0 stalls every register; once halted, all inputs are ignored until reset.
module pc_branch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             isBeq,
    input  logic             isBne,
    input  logic             isJump,
    input  logic             isHalt,
    input  logic             eqIn,
    input  logic [31:0]      brOffset,
    input  logic [25:0]      jumpTarget,
    output logic [31:0]      pcOut,
    output logic [31:0]      pcPlus4,
    output logic             taken,
    output logic             halted,
    output logic             ctrlErr,
    output logic [CNT_W-1:0] takenCount
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc_nxt;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic        taken_nxt;
    logic        err_nxt;
    logic        halt_nxt;
    logic        br_conflict;
    logic        br_cond;
    logic        cnt_sat;

    assign pcPlus4     = pcOut + 32'd4;
    // The word offset is scaled to bytes; its top two bits fall off.
    assign br_target   = pcPlus4 + {brOffset[29:0], 2'b00};
    // Jumps stay inside the current 256 MB region of the sequential PC.
    assign jmp_target  = {pcPlus4[31:28], jumpTarget, 2'b00};
    assign br_conflict = isBeq & isBne;
    // eqIn only matters when exactly one branch kind is decoded.
    assign br_cond     = (isBeq & ~isBne & eqIn) | (isBne & ~isBeq & ~eqIn);
    assign cnt_sat     = &takenCount;
    assign halted      = (state == ST_HALT);

    // Next-PC priority: halt, then jump, then illegal beq+bne, then resolved branch, then fall-through.
    always_comb begin
        pc_nxt    = pcPlus4;
        taken_nxt = 1'b0;
        err_nxt   = 1'b0;
        halt_nxt  = 1'b0;
        if (isHalt) begin
            pc_nxt   = pcOut;
            halt_nxt = 1'b1;
        end else if (isJump) begin
            pc_nxt    = jmp_target;
            taken_nxt = 1'b1;
        end else if (br_conflict) begin
            err_nxt = 1'b1;
        end else if (br_cond) begin
            pc_nxt    = br_target;
            taken_nxt = 1'b1;
        end
    end

    // Commit one update per enabled edge while running; HALT freezes everything except taken, which reads 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            pcOut      <= RESET_PC;
            taken      <= 1'b0;
            ctrlErr    <= 1'b0;
            takenCount <= '0;
        end else if (state == ST_HALT) begin
            taken <= 1'b0;
        end else if (en) begin
            pcOut   <= pc_nxt;
            taken   <= taken_nxt;
            ctrlErr <= err_nxt;
            state   <= halt_nxt ? ST_HALT : ST_RUN;
            if (taken_nxt && !cnt_sat) begin
                takenCount <= takenCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        isBeq, isBne, isJump, isHalt, eqIn;
    logic [31:0] brOffset;
    logic [25:0] jumpTarget;

    logic [31:0] pcOut, pcPlus4, pcOut4, pcPlus4_4;
    logic        taken, halted, ctrlErr;
    logic        taken4, halted4, ctrlErr4;
    logic [15:0] takenCount;
    logic [3:0]  takenCount4;

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    // Reference state, derived straight from the architectural rules.
    logic [31:0] m_pc;
    bit          m_halt, m_taken, m_err;
    int          m_cnt16, m_cnt4;

    always #5 clk = ~clk;

    pc_branch_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .isBeq(isBeq), .isBne(isBne),
        .isJump(isJump), .isHalt(isHalt), .eqIn(eqIn), .brOffset(brOffset),
        .jumpTarget(jumpTarget), .pcOut(pcOut), .pcPlus4(pcPlus4), .taken(taken),
        .halted(halted), .ctrlErr(ctrlErr), .takenCount(takenCount)
    );

    pc_branch_unit #(.RESET_PC(32'h0), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .isBeq(isBeq), .isBne(isBne),
        .isJump(isJump), .isHalt(isHalt), .eqIn(eqIn), .brOffset(brOffset),
        .jumpTarget(jumpTarget), .pcOut(pcOut4), .pcPlus4(pcPlus4_4), .taken(taken4),
        .halted(halted4), .ctrlErr(ctrlErr4), .takenCount(takenCount4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s [%s]: observed %h expected %h", tag, phase, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_halt = 0; m_taken = 0; m_err = 0; m_cnt16 = 0; m_cnt4 = 0;
    endtask

    // One clock edge of the architectural behaviour, in plain arithmetic.
    task automatic model_edge();
        logic [31:0] seq;
        if (m_halt) begin
            m_taken = 0;
            return;
        end
        if (!en) return;
        seq = m_pc + 32'd4;
        if (isHalt) begin
            m_halt = 1; m_taken = 0; m_err = 0;
        end else if (isJump) begin
            m_pc = (seq & 32'hF000_0000) | (32'(jumpTarget) * 4);
            m_taken = 1; m_err = 0;
        end else if (isBeq && isBne) begin
            m_pc = seq; m_taken = 0; m_err = 1;
        end else if ((isBeq && eqIn) || (isBne && !eqIn)) begin
            m_pc = seq + brOffset * 32'd4;
            m_taken = 1; m_err = 0;
        end else begin
            m_pc = seq; m_taken = 0; m_err = 0;
        end
        if (m_taken) begin
            m_cnt16 = (m_cnt16 + 1 > 65535) ? 65535 : m_cnt16 + 1;
            m_cnt4  = (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
        end
    endtask

    task automatic check_all();
        chk("pcOut",       pcOut,               m_pc);
        chk("pcPlus4",     pcPlus4,             m_pc + 32'd4);
        chk("taken",       32'(taken),          32'(m_taken));
        chk("halted",      32'(halted),         32'(m_halt));
        chk("ctrlErr",     32'(ctrlErr),        32'(m_err));
        chk("takenCount",  32'(takenCount),     32'(m_cnt16));
        chk("pcOut_w4",    pcOut4,              m_pc);
        chk("takenCount4", 32'(takenCount4),    32'(m_cnt4));
    endtask

    task automatic set_ctl(input bit e, input bit h, input bit j, input bit bq, input bit bn,
                           input bit eq, input logic [31:0] off, input logic [25:0] jt);
        en = e; isHalt = h; isJump = j; isBeq = bq; isBne = bn; eqIn = eq;
        brOffset = off; jumpTarget = jt;
    endtask

    task automatic idle();
        set_ctl(1, 0, 0, 0, 0, 0, 32'h0, 26'h0);
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs are checked there too.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Reset pulse placed between edges; outputs must reflect it before the next edge.
    task automatic rst_pulse();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] off;
        reset = 1'b1;
        idle();
        #7;
        phase = "reset";
        model_reset();
        check_all();
        chk("reset_pc", pcOut, 32'h0);
        reset = 1'b0;

        // 1: sequential fetch
        phase = "seq";
        step(); chk("seq_pc1", pcOut, 32'h4);
        step(); chk("seq_pc2", pcOut, 32'h8);
        step(); chk("seq_pc3", pcOut, 32'hC);
        chk("seq_cnt", 32'(takenCount), 32'h0);

        // 2: backward beq from 0x100
        phase = "beq";
        rst_pulse();
        repeat (64) step();
        chk("beq_start", pcOut, 32'h100);
        set_ctl(1, 0, 0, 1, 0, 1, 32'hFFFF_FFFE, 26'h0);
        step(); chk("beq_pc", pcOut, 32'h0FC); chk("beq_taken", 32'(taken), 32'h1);
        chk("beq_cnt", 32'(takenCount), 32'h1);
        set_ctl(1, 0, 0, 1, 0, 0, 32'hFFFF_FFFE, 26'h0);
        step(); chk("beq_nt_pc", pcOut, 32'h100); chk("beq_nt_taken", 32'(taken), 32'h0);

        // 3: bne, jump priority, beq+bne conflict
        phase = "bne_jump";
        rst_pulse();
        idle();
        repeat (128) step();
        set_ctl(1, 0, 0, 0, 1, 0, 32'h3, 26'h0);
        step(); chk("bne_pc", pcOut, 32'h210);
        set_ctl(1, 0, 1, 1, 0, 1, 32'h3, 26'h0000040);
        step(); chk("jmp_pc", pcOut, 32'h100); chk("jmp_cnt", 32'(takenCount), 32'h2);
        set_ctl(1, 0, 0, 1, 1, 1, 32'h3, 26'h0);
        step(); chk("conf_pc", pcOut, 32'h104); chk("conf_err", 32'(ctrlErr), 32'h1);
        idle();
        step(); chk("conf_clr", 32'(ctrlErr), 32'h0);

        // 4: wrap-around and stall
        phase = "wrap_stall";
        off = (32'hFFFF_FFF8 - m_pc) >> 2;
        set_ctl(1, 0, 0, 1, 0, 1, off, 26'h0);
        step(); chk("wrap_top", pcOut, 32'hFFFF_FFFC);
        idle();
        step(); chk("wrap_pc", pcOut, 32'h0);
        set_ctl(0, 0, 1, 0, 0, 0, 32'h0, 26'h3FF_FFFF);
        repeat (5) step();
        chk("stall_pc", pcOut, 32'h0);

        // 5: halt wins over jump, holds, and leaves only through reset
        phase = "halt";
        rst_pulse();
        idle();
        repeat (16) step();
        set_ctl(1, 1, 1, 0, 0, 0, 32'h0, 26'h123);
        step(); chk("halt_flag", 32'(halted), 32'h1); chk("halt_pc", pcOut, 32'h40);
        for (int i = 0; i < 10; i++) begin
            set_ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), $urandom, 26'($urandom));
            step();
        end
        chk("halt_hold", pcOut, 32'h40);
        rst_pulse();
        chk("halt_rst_pc", pcOut, 32'h0); chk("halt_rst_flag", 32'(halted), 32'h0);

        // 6: counter saturation (narrow instance)
        phase = "saturate";
        for (int i = 0; i < 20; i++) begin
            set_ctl(1, 0, 1, 0, 0, 0, 32'h0, 26'($urandom));
            step();
        end
        chk("sat4", 32'(takenCount4), 32'hF);
        step(); chk("sat4_hold", 32'(takenCount4), 32'hF);

        // Randomized traffic against the reference model
        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            set_ctl($urandom_range(0, 99) < 85,
                    $urandom_range(0, 63) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 2) == 0,
                    1'($urandom),
                    $urandom_range(0, 1) ? $urandom : (32'($urandom_range(0, 64)) - 32'd32),
                    26'($urandom));
            step();
            if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                rst_pulse();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
Program-counter register and next-PC selector for the single-cycle core. It sits directly downstream of the 32-bit register equality comparator and consumes its 1-bit equal result to resolve beq/bne. It also handles jumps and halt, and keeps a saturating count of redirections (taken branches and jumps) for performance accounting.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the taken-branch counter

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
en  input  1  advance enable; 0 = hold all state (stall)
isBeq  input  1  current instruction is beq
isBne  input  1  current instruction is bne
isJump  input  1  current instruction is j
isHalt  input  1  current instruction is halt
eqIn  input  1  comparator result: 1 = operands equal
brOffset  input  32  sign-extended word offset from the immediate field
jumpTarget  input  26  jump index field
pcOut  output  32  current PC, fetch address
pcPlus4  output  32  combinational pcOut+4, for link/debug
taken  output  1  registered: last committed update was a redirection
halted  output  1  registered: unit is in HALT state
ctrlErr  output  1  registered: last committed update had isBeq and isBne both set
takenCount  output  CNT_W  saturating count of redirections

Behaviour:
- Async reset (any time, including mid-stall or in HALT):
  - pcOut=RESET_PC; taken=0; halted=0; ctrlErr=0; takenCount=0; state=RUN.
- FSM states: RUN, HALT.
  - RUN -> HALT on a rising clk edge with en=1 and isHalt=1.
  - HALT -> RUN only via reset.
- In HALT:
  - pcOut, takenCount and ctrlErr hold; taken=0.
  - All inputs, including en, are ignored.
- In RUN with en=0: every register holds its value, including taken and ctrlErr.
- In RUN with en=1, one update per edge. Next-PC priority:
  1. isHalt=1: PC holds, enter HALT, taken=0. All other control inputs are ignored.
  2. isJump=1: next = {pcPlus4[31:28], jumpTarget, 2'b00}; taken=1.
  3. isBeq=1, isBne=0, eqIn=1: next = pcPlus4 + (brOffset<<2); taken=1.
  4. isBne=1, isBeq=0, eqIn=0: next = pcPlus4 + (brOffset<<2); taken=1.
  5. Otherwise: next = pcPlus4; taken=0.
- isBeq=1 and isBne=1 together (without isHalt or isJump):
  - Illegal; no branch; next = pcPlus4.
  - ctrlErr=1 for that update. ctrlErr clears on the next committed update without the conflict.
- Arithmetic:
  - All adds are 32-bit modulo 2^32; wrap-around is silent.
  - brOffset<<2 discards the top 2 bits.
  - Negative offsets are handled by two's complement.
- Latency:
  - pcOut changes exactly one edge after the decision inputs are sampled.
  - pcPlus4 is combinational from pcOut.
- takenCount increments by 1 on each committed update with taken=1 and saturates at all-ones (no wrap).
- eqIn is sampled only when isBeq or isBne is set; otherwise it is don't-care.

Test Plan:
1. Reset then 3 edges, en=1, no control -> pcOut 0x0, 0x4, 0x8, 0xC; taken=0; takenCount=0.
2. pcOut=0x100, isBeq=1, eqIn=1, brOffset=0xFFFF_FFFE -> pcOut=0x0FC, taken=1, takenCount=1. Then isBeq=1, eqIn=0 -> pcOut=0x100, taken=0.
3. pcOut=0x200:
   - isBne=1, eqIn=0, brOffset=3 -> pcOut=0x210.
   - Next, isJump=1 with isBeq=1, eqIn=1, jumpTarget=0x0000040 -> pcOut=0x100 (jump wins), takenCount=2.
   - Next, isBeq=1, isBne=1 -> pcOut=0x104, ctrlErr=1.
4. pcOut=0xFFFF_FFFC, no control -> pcOut=0x0. Then en=0 for 5 edges with isJump=1 -> pcOut stays 0x0, takenCount unchanged.
5. pcOut=0x40, isHalt=1 together with isJump=1 -> halted=1, pcOut=0x40 holds for 10 edges regardless of inputs. Assert reset between edges -> pcOut=RESET_PC and halted=0 immediately, before the next edge.
6. CNT_W=4: 20 consecutive taken jumps -> takenCount=0xF and stays 0xF.
